// File: rtl/aes_byte_stream_pkg.sv
// Shared definitions for the AES byte-stream front end: FSM encoding,
// block geometry and the byte-lane helper used on both the load and send sides.
package aes_byte_stream_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_e;

    localparam int BYTE_W              = 8;
    localparam int BYTES_PER_BLOCK     = 16;
    localparam int TIMEOUT_MAX_DEFAULT = 1023;

    // Byte k of a block lives at [127-8k -: 8], so byte 0 is the MSB lane.
    function automatic logic [6:0] byte_msb(input logic [3:0] k);
        return 7'd127 - {k, 3'b000};
    endfunction

endpackage

// File: rtl/aes_byte_stream_if.sv
// Byte-stream bundle between a stream partner and the AES front end:
// an inbound valid/ready byte channel and an outbound valid/ready byte channel.
interface aes_byte_stream_if;
    import aes_byte_stream_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );

endinterface

// File: rtl/aes_byte_stream.sv
// Collects 16 inbound bytes into a block, hands it to an external AES core,
// waits (with timeout) for the result and streams the 16 result bytes out.
module aes_byte_stream
    import aes_byte_stream_pkg::*;
#(
    parameter int TIMEOUT_MAX = TIMEOUT_MAX_DEFAULT
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_fDec,
    input  logic [7:0]   i_RxData,
    input  logic         i_RxValid,
    output logic         o_RxReady,
    output logic [7:0]   o_TxData,
    output logic         o_TxValid,
    input  logic         i_TxReady,
    output logic         o_AesStart,
    output logic         o_AesDec,
    output logic [127:0] o_AesText,
    input  logic [127:0] i_AesData,
    input  logic         i_AesDone,
    output logic         o_fBusy,
    output logic         o_fErr
);

    localparam int                WAIT_W     = $clog2(TIMEOUT_MAX + 1);
    localparam logic [3:0]        LAST_BYTE  = 4'(BYTES_PER_BLOCK - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_MAX);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [127:0]        text_q, text_d;
    logic [127:0]        result_q, result_d;
    logic                dec_q, dec_d;

    logic rx_hs_s;
    logic tx_hs_s;
    logic timeout_s;

    assign rx_hs_s   = i_RxValid && (state_q == ST_LOAD);
    assign tx_hs_s   = i_TxReady && (state_q == ST_SEND);
    // Done wins over the timeout in the same cycle.
    assign timeout_s = (state_q == ST_WAIT) && !i_AesDone && (wait_q == WAIT_LIMIT);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (rx_hs_s && (cnt_q == LAST_BYTE)) state_d = ST_START;
                else                                 state_d = ST_LOAD;
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (i_AesDone)      state_d = ST_SEND;
                else if (timeout_s) state_d = ST_LOAD;
                else                state_d = ST_WAIT;
            end
            ST_SEND: begin
                if (tx_hs_s && (cnt_q == LAST_BYTE)) state_d = ST_LOAD;
                else                                 state_d = ST_SEND;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Control outputs are forced low for as long as reset is held.
    always_comb begin
        o_RxReady  = 1'b0;
        o_TxValid  = 1'b0;
        o_AesStart = 1'b0;
        o_fBusy    = 1'b0;
        o_fErr     = 1'b0;
        if (i_Rst) begin
            case (state_q)
                ST_LOAD:  o_RxReady = 1'b1;
                ST_START: begin
                    o_AesStart = 1'b1;
                    o_fBusy    = 1'b1;
                end
                ST_WAIT: begin
                    o_fBusy = 1'b1;
                    o_fErr  = timeout_s;
                end
                ST_SEND: begin
                    o_TxValid = 1'b1;
                    o_fBusy   = 1'b1;
                end
                default: o_fBusy = 1'b1;
            endcase
        end else begin
            o_fBusy = 1'b0;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        text_d   = text_q;
        result_d = result_q;
        dec_d    = dec_q;

        if (rx_hs_s || tx_hs_s) cnt_d = cnt_q + 4'd1;
        else if (timeout_s)     cnt_d = 4'd0;
        else                    cnt_d = cnt_q;

        if (state_q == ST_WAIT) wait_d = wait_q + WAIT_W'(1);
        else                    wait_d = '0;

        if (rx_hs_s) text_d[byte_msb(cnt_q) -: 8] = i_RxData;
        else         text_d = text_q;

        if (rx_hs_s && (cnt_q == 4'd0)) dec_d = i_fDec;
        else                            dec_d = dec_q;

        if ((state_q == ST_WAIT) && i_AesDone) result_d = i_AesData;
        else                                   result_d = result_q;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            cnt_q    <= 4'd0;
            wait_q   <= '0;
            text_q   <= 128'd0;
            result_q <= 128'd0;
            dec_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            text_q   <= text_d;
            result_q <= result_d;
            dec_q    <= dec_d;
        end
    end

    assign o_AesText = text_q;
    assign o_AesDec  = dec_q;
    assign o_TxData  = result_q[byte_msb(cnt_q) -: 8];

endmodule

// File: tb/tb_aes_byte_stream.sv
// Randomized bench for aes_byte_stream: a stand-in AES core, stream drivers and a
// queue-based model that predicts every start pulse, error pulse and outbound byte.
module tb_aes_byte_stream;
    import aes_byte_stream_pkg::*;

    localparam int          TMO = 8;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fdec;
    logic         aes_start, aes_dec, aes_done, busy, ferr;
    logic [127:0] aes_text, aes_data;

    int total = 0;
    int bad = 0;
    int out_blocks = 0;
    bit wd_flag = 1'b0;
    bit core_mute = 1'b0;
    int stray_cnt = 0;
    int tx_mode = 0;

    aes_byte_stream_if bus();

    always #5 clk = ~clk;

    aes_byte_stream #(.TIMEOUT_MAX(TMO)) dut (
        .i_Clk      (clk),
        .i_Rst      (rst_n),
        .i_fDec     (fdec),
        .i_RxData   (bus.rx_data),
        .i_RxValid  (bus.rx_valid),
        .o_RxReady  (bus.rx_ready),
        .o_TxData   (bus.tx_data),
        .o_TxValid  (bus.tx_valid),
        .i_TxReady  (bus.tx_ready),
        .o_AesStart (aes_start),
        .o_AesDec   (aes_dec),
        .o_AesText  (aes_text),
        .i_AesData  (aes_data),
        .i_AesDone  (aes_done),
        .o_fBusy    (busy),
        .o_fErr     (ferr)
    );

    // Stand-in cipher: the FIPS-197 pair is exact, everything else is an arbitrary mapping.
    function automatic logic [127:0] core_fn(input logic [127:0] t, input logic d);
        if (!d && t == PT) return CT;
        if (d && t == CT) return PT;
        return d ? ~(t ^ 128'h5a5a0f0f33cc96690123456789abcdef)
                 : ({t[119:0], t[127:120]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%b exp=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_wide(input string name, input logic [128:0] act, input logic [128:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // AES core model: done 1..4 cycles after start, garbage data whenever done is low.
    initial begin
        int seen = 0;
        logic [127:0] t;
        logic d;
        int lat;
        aes_done = 1'b0;
        aes_data = 128'd0;
        forever begin
            @(posedge clk); #2;
            aes_done = 1'b0;
            aes_data = {$urandom, $urandom, $urandom, $urandom};
            if (seen != stray_cnt) begin
                seen++;
                aes_done = 1'b1;
            end else if (rst_n && aes_start && !core_mute) begin
                t   = aes_text;
                d   = aes_dec;
                lat = $urandom_range(1, 4);
                repeat (lat) @(posedge clk);
                #2;
                aes_done = 1'b1;
                aes_data = core_fn(t, d);
            end
        end
    end

    // Outbound ready patterns: 0 always, 1 toggling 1010, 2 random, 3 stalled.
    initial begin
        int c = 0;
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            c++;
            case (tx_mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = (c % 2 == 0);
                2:       bus.tx_ready = 1'($urandom % 2);
                default: bus.tx_ready = 1'b0;
            endcase
        end
    end

    // Model and compare, sampled on the falling edge.
    initial begin
        logic [7:0]   in_q[$];
        logic [128:0] start_q[$];
        logic [7:0]   exp_q[$];
        logic [128:0] sv;
        logic [127:0] blk, res, out_cur;
        logic [7:0]   prev_data;
        logic         cur_dec;
        int cyc = 0;
        int out_n = 0;
        int start_due = -10;
        int err_due = -10;
        bit awaiting = 1'b0;
        bit done_prev = 1'b0;
        bit stall_prev = 1'b0;
        bit wd_seen = 1'b0;
        cur_dec = 1'b0;
        prev_data = 8'd0;
        out_cur = 128'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk_byte("reset_outs", {3'b000, bus.rx_ready, bus.tx_valid, aes_start, busy, ferr}, 8'd0);
                in_q.delete();
                start_q.delete();
                exp_q.delete();
                out_n = 0;
                awaiting = 1'b0;
                done_prev = 1'b0;
                stall_prev = 1'b0;
            end else begin
                chk_bit("busy_vs_ready", busy, !bus.rx_ready);
                chk_bit("start_pulse", aes_start, cyc == start_due);
                chk_bit("ferr_pulse", ferr, cyc == err_due);
                if (cyc == err_due + 1) chk_bit("ready_after_err", bus.rx_ready, 1'b1);
                if (done_prev) chk_bit("tx_latency", bus.tx_valid, 1'b1);
                done_prev = awaiting && aes_done;
                if (done_prev) awaiting = 1'b0;

                if (aes_start) begin
                    chk_bit("start_has_block", start_q.size() != 0, 1'b1);
                    if (start_q.size() != 0) begin
                        sv = start_q.pop_front();
                        chk_wide("start_block", {aes_dec, aes_text}, sv);
                        if (core_mute) begin
                            err_due = cyc + 9;
                        end else begin
                            awaiting = 1'b1;
                            res = core_fn(sv[127:0], sv[128]);
                            for (int k = 0; k < 16; k++) exp_q.push_back(res[127-8*k -: 8]);
                        end
                    end
                end

                if (bus.rx_valid && bus.rx_ready) begin
                    if (in_q.size() == 0) cur_dec = fdec;
                    in_q.push_back(bus.rx_data);
                    if (in_q.size() == 16) begin
                        for (int k = 0; k < 16; k++) blk[127-8*k -: 8] = in_q[k];
                        start_q.push_back({cur_dec, blk});
                        in_q.delete();
                        start_due = cyc + 1;
                    end
                end

                if (bus.tx_valid) begin
                    if (stall_prev) chk_byte("tx_stable", bus.tx_data, prev_data);
                    if (bus.tx_ready) begin
                        chk_bit("tx_has_expect", exp_q.size() != 0, 1'b1);
                        if (exp_q.size() != 0) chk_byte("tx_byte", bus.tx_data, exp_q.pop_front());
                        out_cur[127-8*out_n -: 8] = bus.tx_data;
                        out_n++;
                        if (out_n == 16) begin
                            out_n = 0;
                            out_blocks++;
                            if (out_blocks == 1) chk_wide("pin_encrypt", {1'b0, out_cur}, {1'b0, CT});
                            if (out_blocks == 2) chk_wide("pin_decrypt", {1'b0, out_cur}, {1'b0, PT});
                        end
                    end
                end
                stall_prev = bus.tx_valid && !bus.tx_ready;
                prev_data = bus.tx_data;
            end
            if (!wd_seen) begin
                chk_bit("watchdog", wd_flag, 1'b0);
                wd_seen = wd_flag;
            end
        end
    end

    // mode 0: valid every cycle, 1: every 3rd cycle, 2: random.
    task automatic rx_block(input logic [127:0] blk, input logic dec, input int mode, input int nbytes);
        int k = 0;
        int c = 0;
        int g = 0;
        while (k < nbytes && g < 600) begin
            @(posedge clk); #1;
            case (mode)
                0:       bus.rx_valid = 1'b1;
                1:       bus.rx_valid = (c % 3 == 0);
                default: bus.rx_valid = 1'($urandom % 2);
            endcase
            bus.rx_data = blk[127-8*k -: 8];
            fdec = (k == 0) ? dec : 1'($urandom % 2);
            c++;
            g++;
            @(negedge clk);
            if (bus.rx_valid && bus.rx_ready) k++;
        end
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        if (k < nbytes) wd_flag = 1'b1;
    endtask

    task automatic wait_blocks(input int n);
        int g = 0;
        while (out_blocks < n && g < 3000) begin
            @(posedge clk);
            g++;
        end
        if (out_blocks < n) wd_flag = 1'b1;
        #1;
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        fdec = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'd0;
        tx_mode = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        rx_block(PT, 1'b0, 0, 16);
        wait_blocks(1);
        rx_block(CT, 1'b1, 0, 16);
        wait_blocks(2);

        tx_mode = 1;
        rx_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1, 16);
        wait_blocks(3);

        for (int i = 0; i < 5; i++) begin
            tx_mode = 2;
            rx_block({$urandom, $urandom, $urandom, $urandom}, 1'($urandom % 2), 2, 16);
            wait_blocks(4 + i);
        end

        tx_mode = 0;
        core_mute = 1'b1;
        rx_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 16);
        repeat (20) @(posedge clk);
        core_mute = 1'b0;
        rx_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, 16);
        wait_blocks(9);

        stray_cnt++;
        repeat (4) @(posedge clk);
        rx_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 16);
        wait_blocks(10);

        rx_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 7);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rx_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 16);
        wait_blocks(11);

        tx_mode = 3;
        rx_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, 16);
        g = 0;
        while (!bus.tx_valid && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (!bus.tx_valid) wd_flag = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tx_mode = 0;
        rx_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 16);
        wait_blocks(12);

        repeat (10) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_byte_stream.md
AES_BYTE_STREAM -- requirements
Module: aes_byte_stream

Interface
REQ-001 SHALL have parameter TIMEOUT_MAX, default 1023, the maximum number of cycles spent in WAIT before abort.
REQ-002 SHALL have port i_Clk  in  1  the single clock; all logic is on the rising edge.
REQ-003 SHALL have port i_Rst  in  1  the reset, which is synchronous and active-low.
REQ-004 SHALL have port i_fDec  in  1  the block mode (1 = decrypt), sampled on the first byte of each block.
REQ-005 SHALL have port i_RxData  in  8  the inbound byte.
REQ-006 SHALL have port i_RxValid  in  1  the inbound byte valid.
REQ-007 SHALL have port o_RxReady  out  1  the inbound byte accept.
REQ-008 SHALL have port o_TxData  out  8  the outbound byte.
REQ-009 SHALL have port o_TxValid  out  1  the outbound byte valid.
REQ-010 SHALL have port i_TxReady  in  1  the outbound byte accept.
REQ-011 SHALL have port o_AesStart  out  1  the start pulse to the AES core.
REQ-012 SHALL have port o_AesDec  out  1  the mode to the AES core.
REQ-013 SHALL have port o_AesText  out  128  the assembled block to the AES core.
REQ-014 SHALL have port i_AesData  in  128  the AES core result, valid only while i_AesDone = 1.
REQ-015 SHALL have port i_AesDone  in  1  the AES core done pulse.
REQ-016 SHALL have port o_fBusy  out  1  high in every state except LOAD.
REQ-017 SHALL have port o_fErr  out  1  a one-cycle timeout pulse.

Function
REQ-018 SHALL implement FSM states LOAD, START, WAIT and SEND.
REQ-019 SHALL drive o_RxReady = 1 only in LOAD; a byte is accepted on i_RxValid & o_RxReady.
REQ-020 SHALL place byte k (k = 0..15) at o_AesText[127-8k -: 8], so that the first byte is the MSB.
REQ-021 SHALL latch i_fDec into o_AesDec on acceptance of byte 0; changes to i_fDec during the rest of the block are ignored.
REQ-022 SHALL use a 4-bit byte counter that increments on each handshake and wraps 15 -> 0.
REQ-023 SHALL go LOAD -> START on acceptance of byte 15.
REQ-024 SHALL assert o_AesStart for exactly one cycle in START, one cycle after byte 15 is accepted, with o_AesText and o_AesDec stable in that cycle.
REQ-025 SHALL go START -> WAIT unconditionally.
REQ-026 SHALL hold o_AesText and o_AesDec constant from START until leaving WAIT.
REQ-027 SHALL, in WAIT with i_AesDone = 1, capture i_AesData into the result register in the same edge and go WAIT -> SEND.
REQ-028 SHALL ignore i_AesDone in LOAD, START and SEND.
REQ-029 SHALL count cycles spent in WAIT with a wait counter.
REQ-030 SHALL, when the wait counter reaches TIMEOUT_MAX without i_AesDone, pulse o_fErr for one cycle, discard the block and go WAIT -> LOAD with the byte counter at 0.
REQ-031 SHALL give i_AesDone priority over the timeout when both occur in the same cycle.
REQ-032 SHALL, in SEND, drive o_TxValid = 1 with o_TxData = result[127-8k -: 8] for k = byte counter.
REQ-033 SHALL hold o_TxData stable while o_TxValid & !i_TxReady.
REQ-034 SHALL go SEND -> LOAD on the i_TxReady handshake of byte 15.
REQ-035 SHALL sustain throughput of one byte per cycle on each side when the partner is always ready.
REQ-036 SHALL give a minimum latency of 1 cycle from the byte-15 handshake to o_AesStart.
REQ-037 SHALL give a latency of 1 cycle from i_AesDone to the first o_TxValid.

Reset
REQ-038 SHALL, with i_Rst = 0 at a clock edge, set state = LOAD and the byte counter, wait counter, result register, o_AesText and o_AesDec to 0.
REQ-039 SHALL, while in reset, drive o_RxReady = 0, o_TxValid = 0, o_AesStart = 0, o_fBusy = 0 and o_fErr = 0.
REQ-040 SHALL, on reset asserted mid-block, discard any partial input or output block with no further pulse on o_AesStart or o_TxValid.

Structure
REQ-041 SHALL take the state encoding, BYTES_PER_BLOCK = 16 and the default TIMEOUT_MAX from the shared AES package.
REQ-042 SHALL contain no sub-module; it is a single module whose o_Aes* ports connect directly to the AES core.

Verification
REQ-043 SHALL cover encrypt: key 000102030405060708090a0b0c0d0e0f, bytes 00 11 22 .. ff, i_fDec = 0 -> one o_AesStart pulse, Tx bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
REQ-044 SHALL cover decrypt: same key, bytes 69 c4 .. 5a, i_fDec = 1 -> Tx bytes 00 11 22 .. ff.
REQ-045 SHALL cover backpressure: i_RxValid asserted every 3rd cycle and i_TxReady toggling 1010 -> no byte lost or duplicated and o_TxData stable while stalled.
REQ-046 SHALL cover timeout: the core model never asserts done and TIMEOUT_MAX = 8 -> o_fErr pulse 9 cycles after START, then o_RxReady = 1.
REQ-047 SHALL cover reset mid-block: i_Rst = 0 after 7 bytes, then 16 new bytes -> output equals the encryption of the new 16 bytes only.
REQ-048 SHALL cover a stray done: i_AesDone pulsed during LOAD -> no state change and no o_TxValid.
